// File: rtl/cam_line_streamer.sv
// cam_line_streamer
//   Synthetic camera line transmitter. Each accepted start renders one scan
//   line holding a single rectangular object on a background.
//   Every output is a flop, and it changes on the edge that samples start.
//   The first pixel therefore appears in the cycle right after start was seen.
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   start                           line request (ignored while busy)
//   obj_center, obj_half_w          object window, latched on accepted start
//   obj_val, bg_val, sparse         intensities / mode, latched on accepted start
//   busy                            line in progress
//   line_done                       one-cycle completion pulse (state is IDLE)
//   valid_pixel, pixel_val, x_coord pixel stream (value/x are 0 when not valid)
//   end_of_line                     one-cycle line sync pulse
//   line_count                      lines completed, wraps at 16 bits
module cam_line_streamer #(
    parameter int LINE_W   = 640,
    parameter int XW       = 10,
    parameter int PW       = 8,
    parameter int GAP_PRE  = 1,
    parameter int GAP_POST = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [XW-1:0] obj_center,
    input  logic [XW-1:0] obj_half_w,
    input  logic [PW-1:0] obj_val,
    input  logic [PW-1:0] bg_val,
    input  logic          sparse,
    output logic          busy,
    output logic          line_done,
    output logic          valid_pixel,
    output logic          end_of_line,
    output logic [PW-1:0] pixel_val,
    output logic [XW-1:0] x_coord,
    output logic [15:0]   line_count
);
    localparam int SW = XW + 2;
    localparam logic [XW-1:0] X_LAST = XW'(LINE_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_PIX, S_GAP_A, S_EOL, S_GAP_B} state_t;

    // Zero-length gaps collapse the corresponding state out of the sequence.
    localparam state_t AFTER_PIX = (GAP_PRE  > 0) ? S_GAP_A : S_EOL;
    localparam state_t AFTER_EOL = (GAP_POST > 0) ? S_GAP_B : S_IDLE;

    state_t               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic signed [SW-1:0] lo_q, lo_d, hi_q, hi_d;
    logic                 win_q, win_d;
    logic                 sparse_q, sparse_d;
    logic [PW-1:0]        obj_q, obj_d, bg_q, bg_d;
    logic                 busy_q, busy_d, done_q, done_d, valid_q, valid_d, eol_q, eol_d;
    logic [PW-1:0]        pix_q, pix_d;
    logic [XW-1:0]        x_q, x_d;
    logic [15:0]          line_count_q, line_count_d;

    logic signed [SW-1:0] lo_s, hi_s, lo_c, hi_c;
    logic                 win_c;
    logic [XW-1:0]        nx, last_x;

    function automatic logic in_win(input logic [XW-1:0] x, input logic signed [SW-1:0] lo,
                                    input logic signed [SW-1:0] hi, input logic w);
        logic signed [SW-1:0] xs;
        xs = $signed({2'b00, x});
        return w && (xs >= lo) && (xs <= hi);
    endfunction

    // Window from the live inputs. The signed arithmetic is wide enough for
    // center+half_w-1 and for a negative center-half_w.
    always_comb begin
        lo_s  = $signed({2'b00, obj_center}) - $signed({2'b00, obj_half_w});
        hi_s  = $signed({2'b00, obj_center}) + $signed({2'b00, obj_half_w}) - $signed(SW'(1));
        lo_c  = (lo_s < $signed(SW'(0))) ? $signed(SW'(0)) : lo_s;
        hi_c  = (hi_s > $signed(SW'(LINE_W - 1))) ? $signed(SW'(LINE_W - 1)) : hi_s;
        win_c = (obj_half_w != '0) && (lo_c <= hi_c);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        win_d        = win_q;
        sparse_d     = sparse_q;
        obj_d        = obj_q;
        bg_d         = bg_q;
        line_count_d = line_count_q;
        nx           = '0;
        last_x       = sparse_q ? hi_q[XW-1:0] : X_LAST;
        valid_d      = 1'b0;
        eol_d        = 1'b0;
        done_d       = 1'b0;
        pix_d        = '0;
        x_d          = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lo_d     = lo_c;
                    hi_d     = hi_c;
                    win_d    = win_c;
                    sparse_d = sparse;
                    obj_d    = obj_val;
                    bg_d     = bg_val;
                    cnt_d    = '0;
                    if (!sparse) begin
                        state_d = S_PIX;
                        nx      = '0;
                    end else if (win_c) begin
                        state_d = S_PIX;
                        nx      = lo_c[XW-1:0];
                    end else begin
                        state_d = AFTER_PIX;
                    end
                end
            end
            S_PIX: begin
                // The last x is always <= LINE_W-1, so the counter cannot wrap.
                if (x_q == last_x) begin
                    state_d = AFTER_PIX;
                    cnt_d   = '0;
                end else begin
                    nx = x_q + XW'(1);
                end
            end
            S_GAP_A: begin
                if (cnt_q == 16'(GAP_PRE - 1)) state_d = S_EOL;
                else                           cnt_d   = cnt_q + 16'd1;
            end
            S_EOL: begin
                state_d = AFTER_EOL;
                cnt_d   = '0;
            end
            S_GAP_B: begin
                if (cnt_q == 16'(GAP_POST - 1)) state_d = S_IDLE;
                else                            cnt_d   = cnt_q + 16'd1;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the state being entered, so they line up with it.
        if (state_d == S_PIX) begin
            valid_d = 1'b1;
            x_d     = nx;
            pix_d   = (sparse_d || in_win(nx, lo_d, hi_d, win_d)) ? obj_d : bg_d;
        end
        if (state_d == S_EOL) begin
            eol_d        = 1'b1;
            line_count_d = line_count_q + 16'd1;
        end
        if (state_d == S_IDLE && state_q != S_IDLE) done_d = 1'b1;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            win_q        <= 1'b0;
            sparse_q     <= 1'b0;
            obj_q        <= '0;
            bg_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            valid_q      <= 1'b0;
            eol_q        <= 1'b0;
            pix_q        <= '0;
            x_q          <= '0;
            line_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            win_q        <= win_d;
            sparse_q     <= sparse_d;
            obj_q        <= obj_d;
            bg_q         <= bg_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            valid_q      <= valid_d;
            eol_q        <= eol_d;
            pix_q        <= pix_d;
            x_q          <= x_d;
            line_count_q <= line_count_d;
        end
    end

    assign busy        = busy_q;
    assign line_done   = done_q;
    assign valid_pixel = valid_q;
    assign end_of_line = eol_q;
    assign pixel_val   = pix_q;
    assign x_coord     = x_q;
    assign line_count  = line_count_q;
endmodule

// File: tb/tb_cam_line_streamer.sv
// Directed bench for cam_line_streamer. Cycle numbering: the cycle in which
// start is high and sampled is cycle 0, and the following cycles are 1, 2, ...
module tb_cam_line_streamer;
    localparam int XW = 10;
    localparam int PW = 8;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, sparse = 1'b0;
    logic [XW-1:0] obj_center = '0, obj_half_w = '0;
    logic [PW-1:0] obj_val = '0, bg_val = '0;
    logic          busy, line_done, valid_pixel, end_of_line;
    logic [PW-1:0] pixel_val;
    logic [XW-1:0] x_coord;
    logic [15:0]   line_count;

    cam_line_streamer #(.LINE_W(640), .XW(XW), .PW(PW), .GAP_PRE(1), .GAP_POST(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .obj_center(obj_center), .obj_half_w(obj_half_w),
        .obj_val(obj_val), .bg_val(bg_val), .sparse(sparse), .busy(busy), .line_done(line_done),
        .valid_pixel(valid_pixel), .end_of_line(end_of_line), .pixel_val(pixel_val),
        .x_coord(x_coord), .line_count(line_count)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int n_pix, first_x, last_x, first_cyc, last_cyc, eol_cyc, done_cyc, n_eol, badv, gaps, zviol;
    logic busy_at_done;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic setup(input logic sp, input int c, input int hw, input int ov, input int bv);
        sparse = sp; obj_center = XW'(c); obj_half_w = XW'(hw); obj_val = PW'(ov); bg_val = PW'(bv);
    endtask

    // Issues one start and records the line until line_done or the budget runs out.
    // The config inputs are scrambled right after the accepted start.
    task automatic capture(input int budget, input int elo, input int ehi, input int ov, input int bv);
        int prev_x, expv;
        n_pix = 0; first_x = -1; last_x = -1; first_cyc = -1; last_cyc = -1; eol_cyc = -1;
        done_cyc = -1; n_eol = 0; badv = 0; gaps = 0; zviol = 0; busy_at_done = 1'bx; prev_x = -1;
        start = 1'b1; step(); start = 1'b0;
        obj_center = ~obj_center; obj_half_w = obj_half_w + XW'(3);
        obj_val = ~obj_val; bg_val = ~bg_val; sparse = ~sparse;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (valid_pixel) begin
                if (n_pix == 0) begin first_x = int'(x_coord); first_cyc = cyc; end
                else if (int'(x_coord) != prev_x + 1) gaps++;
                expv = (int'(x_coord) >= elo && int'(x_coord) <= ehi) ? ov : bv;
                if (int'(pixel_val) != expv) badv++;
                n_pix++; prev_x = int'(x_coord); last_x = prev_x; last_cyc = cyc;
            end else if (pixel_val !== '0 || x_coord !== '0) zviol++;
            if (end_of_line) begin n_eol++; eol_cyc = cyc; end
            if (line_done) begin done_cyc = cyc; busy_at_done = busy; break; end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; step(); step();
        checks++; if ({busy, line_done, valid_pixel, end_of_line} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, line_done, valid_pixel, end_of_line}); end
        checks++; if ({pixel_val, x_coord, line_count} !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", {pixel_val, x_coord, line_count}); end
        rst_n = 1'b1; step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy got=%b exp=0", busy); end
    endtask

    task automatic test_sparse();
        setup(1'b1, 300, 5, 100, 7);
        capture(100, 295, 304, 100, 7);
        checks++; if (n_pix != 10) begin failures++; $display("FAIL sparse_npix got=%0d exp=10", n_pix); end
        checks++; if (first_x != 295 || last_x != 304) begin failures++; $display("FAIL sparse_x got=%0d..%0d exp=295..304", first_x, last_x); end
        checks++; if (first_cyc != 1 || last_cyc != 10) begin failures++; $display("FAIL sparse_pixcyc got=%0d..%0d exp=1..10", first_cyc, last_cyc); end
        checks++; if (badv != 0 || gaps != 0 || zviol != 0) begin failures++; $display("FAIL sparse_vals badv=%0d gaps=%0d zviol=%0d exp=0", badv, gaps, zviol); end
        checks++; if (eol_cyc != 12) begin failures++; $display("FAIL sparse_eol got=%0d exp=12", eol_cyc); end
        checks++; if (done_cyc != 14 || busy_at_done !== 1'b0) begin failures++; $display("FAIL sparse_done got=%0d busy=%b exp=14 busy=0", done_cyc, busy_at_done); end
        checks++; if (line_count !== 16'd1) begin failures++; $display("FAIL sparse_count got=%0d exp=1", line_count); end
    endtask

    task automatic test_dense();
        setup(1'b0, 350, 5, 100, 3);
        capture(800, 345, 354, 100, 3);
        checks++; if (n_pix != 640 || gaps != 0) begin failures++; $display("FAIL dense_npix got=%0d gaps=%0d exp=640 gaps=0", n_pix, gaps); end
        checks++; if (first_x != 0 || last_x != 639 || last_cyc != 640) begin failures++; $display("FAIL dense_x got=%0d..%0d@%0d exp=0..639@640", first_x, last_x, last_cyc); end
        checks++; if (badv != 0) begin failures++; $display("FAIL dense_vals bad=%0d exp=0", badv); end
        checks++; if (eol_cyc != 642 || done_cyc != 644) begin failures++; $display("FAIL dense_timing eol=%0d done=%0d exp=642/644", eol_cyc, done_cyc); end
        checks++; if (line_count !== 16'd2) begin failures++; $display("FAIL dense_count got=%0d exp=2", line_count); end
    endtask

    task automatic test_clamp();
        setup(1'b1, 2, 5, 77, 0);
        capture(100, 0, 6, 77, 0);
        checks++; if (n_pix != 7 || first_x != 0 || last_x != 6 || badv != 0) begin failures++; $display("FAIL clamp_lo got=%0d px %0d..%0d bad=%0d exp=7 px 0..6", n_pix, first_x, last_x, badv); end
        checks++; if (eol_cyc != 9 || done_cyc != 11) begin failures++; $display("FAIL clamp_lo_timing eol=%0d done=%0d exp=9/11", eol_cyc, done_cyc); end
        setup(1'b1, 638, 5, 200, 0);
        capture(100, 633, 639, 200, 0);
        checks++; if (n_pix != 7 || first_x != 633 || last_x != 639 || badv != 0) begin failures++; $display("FAIL clamp_hi got=%0d px %0d..%0d bad=%0d exp=7 px 633..639", n_pix, first_x, last_x, badv); end
        checks++; if (line_count !== 16'd4) begin failures++; $display("FAIL clamp_count got=%0d exp=4", line_count); end
    endtask

    task automatic test_empty();
        setup(1'b1, 100, 0, 50, 0);
        capture(50, 0, -1, 50, 0);
        checks++; if (n_pix != 0 || zviol != 0) begin failures++; $display("FAIL empty_npix got=%0d zviol=%0d exp=0", n_pix, zviol); end
        checks++; if (eol_cyc != 2 || done_cyc != 4) begin failures++; $display("FAIL empty_timing eol=%0d done=%0d exp=2/4", eol_cyc, done_cyc); end
        checks++; if (line_count !== 16'd5) begin failures++; $display("FAIL empty_count got=%0d exp=5", line_count); end
        // Window entirely past the right edge collapses to empty.
        setup(1'b1, 700, 5, 50, 0);
        capture(50, 0, -1, 50, 0);
        checks++; if (n_pix != 0 || eol_cyc != 2 || line_count !== 16'd6) begin failures++; $display("FAIL empty_right npix=%0d eol=%0d cnt=%0d exp=0/2/6", n_pix, eol_cyc, line_count); end
    endtask

    task automatic test_back_to_back();
        int np, ne, nd, d1, d2, sf, sx;
        // start pulsed mid-line must not queue a second line
        setup(1'b1, 300, 5, 100, 0);
        np = 0; ne = 0; nd = 0;
        start = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            step(); start = (cyc == 5);
            if (valid_pixel) np++;
            if (end_of_line) ne++;
            if (line_done) nd++;
        end
        checks++; if (np != 10 || ne != 1 || nd != 1) begin failures++; $display("FAIL ignore_start px=%0d eol=%0d done=%0d exp=10/1/1", np, ne, nd); end
        checks++; if (line_count !== 16'd7) begin failures++; $display("FAIL ignore_count got=%0d exp=7", line_count); end
        // start held through line_done: next line begins the following cycle
        np = 0; ne = 0; nd = 0; d1 = -1; d2 = -1; sf = -1; sx = -1;
        start = 1'b1;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            step();
            if (cyc == 15) start = 1'b0;
            if (valid_pixel) begin np++; if (cyc > 14 && sf < 0) begin sf = cyc; sx = int'(x_coord); end end
            if (end_of_line) ne++;
            if (line_done) begin nd++; if (d1 < 0) d1 = cyc; else d2 = cyc; end
        end
        checks++; if (sf != 15 || sx != 295) begin failures++; $display("FAIL b2b_first cyc=%0d x=%0d exp=15/295", sf, sx); end
        checks++; if (np != 20 || ne != 2 || nd != 2 || d1 != 14 || d2 != 28) begin failures++; $display("FAIL b2b_lines px=%0d eol=%0d done=%0d@%0d,%0d exp=20/2/2@14,28", np, ne, nd, d1, d2); end
        checks++; if (line_count !== 16'd9) begin failures++; $display("FAIL b2b_count got=%0d exp=9", line_count); end
        // counter wrap
        force dut.line_count_q = 16'hFFFF;
        step();
        release dut.line_count_q;
        checks++; if (line_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%h exp=ffff", line_count); end
        setup(1'b1, 10, 0, 1, 0);
        capture(50, 0, -1, 1, 0);
        checks++; if (line_count !== 16'd0 || eol_cyc != 2) begin failures++; $display("FAIL wrap_count got=%h eol=%0d exp=0000/2", line_count, eol_cyc); end
    endtask

    task automatic test_reset_midline();
        int ne;
        setup(1'b0, 350, 5, 100, 3);
        start = 1'b1; step(); start = 1'b0;
        step(); step(); step();
        checks++; if (valid_pixel !== 1'b1 || x_coord !== XW'(3)) begin failures++; $display("FAIL midline_pre valid=%b x=%0d exp=1/3", valid_pixel, x_coord); end
        rst_n = 1'b0; #1;
        checks++; if ({busy, line_done, valid_pixel, end_of_line} !== 4'b0 || {pixel_val, x_coord, line_count} !== '0) begin failures++; $display("FAIL midline_async flags=%b data=%h exp=0", {busy, line_done, valid_pixel, end_of_line}, {pixel_val, x_coord, line_count}); end
        ne = 0;
        for (int i = 0; i < 3; i++) begin step(); if (end_of_line || line_done) ne++; end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin step(); if (end_of_line || line_done || valid_pixel) ne++; end
        checks++; if (ne != 0 || busy !== 1'b0) begin failures++; $display("FAIL midline_quiet events=%0d busy=%b exp=0/0", ne, busy); end
        setup(1'b1, 300, 5, 100, 0);
        capture(100, 295, 304, 100, 0);
        checks++; if (n_pix != 10 || eol_cyc != 12 || done_cyc != 14 || line_count !== 16'd1) begin failures++; $display("FAIL midline_clean px=%0d eol=%0d done=%0d cnt=%0d exp=10/12/14/1", n_pix, eol_cyc, done_cyc, line_count); end
    endtask

    initial begin
        test_reset();
        test_sparse();
        test_dense();
        test_clamp();
        test_empty();
        test_back_to_back();
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
